// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Synchronizes an asynchronous pulse train, detects rising edges and
//   measures the interval between consecutive edges in clock cycles.
//   A timeout level flags loss of signal; a toggle output flips on every
//   accepted edge (suitable for driving an LED).
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   asynchronous active-high reset
//   pulse_in     in   asynchronous pulse train
//   period       out  last measured interval between rising edges (cycles)
//   period_valid out  one-cycle strobe when period has just been updated
//   timeout      out  high while no rising edge for TIMEOUT cycles
//   toggle       out  inverts on every accepted rising edge
//   edge_count   out  count of accepted rising edges, wraps 255 -> 0
module pulse_period_meter #(
  parameter int WIDTH   = 26,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic             toggle,
  output logic [7:0]       edge_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  // Counter value on the last cycle before loss of signal is declared.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  state_t           state;
  logic [WIDTH-1:0] cnt;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      toggle       <= 1'b0;
      edge_count   <= 8'd0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state      <= MEASURE;
            toggle     <= ~toggle;
            edge_count <= edge_count + 8'd1;
          end
        end
        MEASURE: begin
          // A rise on the final count wins over the timeout.
          if (rise) begin
            period       <= cnt + WIDTH'(1);
            period_valid <= 1'b1;
            cnt          <= '0;
            toggle       <= ~toggle;
            edge_count   <= edge_count + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state   <= LOST;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        LOST: begin
          cnt     <= '0;
          timeout <= 1'b1;
          // The first edge after loss only restarts measurement.
          if (rise) begin
            state      <= MEASURE;
            timeout    <= 1'b0;
            toggle     <= ~toggle;
            edge_count <= edge_count + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
module tb_pulse_period_meter;

  localparam int WIDTH   = 26;
  localparam int TIMEOUT = 20;

  logic             clock;
  logic             reset;
  logic             pulse_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             toggle;
  logic [7:0]       edge_count;

  pulse_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .pulse_in(pulse_in),
    .period(period),
    .period_valid(period_valid),
    .timeout(timeout),
    .toggle(toggle),
    .edge_count(edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: timestamps of accepted edges, not a state machine.
  bit               hist[$];     // pulse_in value sampled at each edge since reset
  int               last_k;      // edge index of last accepted rise update
  bit               armed;       // a reference edge exists and no timeout yet
  logic [WIDTH-1:0] m_period;
  logic             m_valid;
  logic             m_timeout;
  logic             m_toggle;
  logic [7:0]       m_count;

  int obs_valids;
  bit obs_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    last_k    = 0;
    armed     = 1'b0;
    m_period  = '0;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    m_toggle  = 1'b0;
    m_count   = 8'd0;
  endtask

  // A sample taken at edge k becomes an accepted rise in the update at
  // edge k+2 when the previous sample was low.
  task automatic model_edge(input bit p);
    int k;
    bit a, b;
    hist.push_back(p);
    k = hist.size() - 1;
    a = (k >= 2) ? hist[k-2] : 1'b0;
    b = (k >= 3) ? hist[k-3] : 1'b0;
    m_valid = 1'b0;
    if (a && !b) begin
      if (armed) begin
        m_period = WIDTH'(k - last_k);
        m_valid  = 1'b1;
      end
      armed     = 1'b1;
      last_k    = k;
      m_timeout = 1'b0;
      m_toggle  = ~m_toggle;
      m_count   = m_count + 8'd1;
    end else if (armed && (k - last_k) >= TIMEOUT) begin
      m_timeout = 1'b1;
      armed     = 1'b0;
    end
  endtask

  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clock);
    #1;
    model_edge(p);
    check("period", 32'(period), 32'(m_period));
    check("period_valid", 32'(period_valid), 32'(m_valid));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("toggle", 32'(toggle), 32'(m_toggle));
    check("edge_count", 32'(edge_count), 32'(m_count));
    if (period_valid) obs_valids++;
    if (timeout) obs_timeout = 1'b1;
  endtask

  // Asserts reset asynchronously and checks that outputs clear before any edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_period", 32'(period), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_toggle", 32'(toggle), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    @(posedge clock);
    #1;
    model_reset();
    #1 reset = 1'b0;
  endtask

  typedef struct {
    int unsigned      high_cycles;
    int unsigned      spacing;
    int unsigned      pulses;
    logic [WIDTH-1:0] exp_period;
    int unsigned      exp_valids;
    logic             exp_toggle;
    logic [7:0]       exp_count;
    logic             exp_timeout_seen;
  } vec_t;

  vec_t table_v[7];

  initial begin
    int run_len;
    logic lvl;

    table_v[0] = '{1, 11,   5, 26'd11,   4, 1'b1, 8'd5,  1'b0};
    table_v[1] = '{6, 15,   2, 26'd15,   1, 1'b0, 8'd2,  1'b0};
    table_v[2] = '{1, 20,   3, 26'd20,   2, 1'b1, 8'd3,  1'b0};
    table_v[3] = '{1, 21,   2, 26'd0,    0, 1'b0, 8'd2,  1'b1};
    table_v[4] = '{3,  4, 257, 26'd4,  256, 1'b1, 8'd1,  1'b0};
    table_v[5] = '{1,  2,  10, 26'd2,    9, 1'b0, 8'd10, 1'b0};
    table_v[6] = '{4,  7,   3, 26'd7,    2, 1'b1, 8'd3,  1'b0};

    pulse_in = 1'b0;
    reset    = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Table-driven pulse trains, each from a fresh reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      obs_valids  = 0;
      obs_timeout = 1'b0;
      for (int p = 0; p < int'(table_v[i].pulses); p++) begin
        int low_len;
        low_len = (p == int'(table_v[i].pulses) - 1) ? 3
                : int'(table_v[i].spacing - table_v[i].high_cycles);
        repeat (table_v[i].high_cycles) step(1'b1);
        repeat (low_len) step(1'b0);
      end
      check("tbl_valids", 32'(obs_valids), 32'(table_v[i].exp_valids));
      check("tbl_period", 32'(period), 32'(table_v[i].exp_period));
      check("tbl_toggle", 32'(toggle), 32'(table_v[i].exp_toggle));
      check("tbl_edge_count", 32'(edge_count), 32'(table_v[i].exp_count));
      check("tbl_timeout_seen", 32'(obs_timeout), 32'(table_v[i].exp_timeout_seen));
      $display("record %0d: spacing=%0d pulses=%0d valids=%0d period=%0d edge_count=%0d",
               i, table_v[i].spacing, table_v[i].pulses, obs_valids, period, edge_count);
    end

    // Timeout exactly TIMEOUT cycles after the rise update, then recovery.
    do_reset();
    step(1'b1); step(1'b0); step(1'b0);
    repeat (TIMEOUT - 1) step(1'b0);
    check("to_not_yet", 32'(timeout), 32'd0);
    step(1'b0);
    check("to_asserted", 32'(timeout), 32'd1);
    step(1'b1); step(1'b0); step(1'b0);
    check("to_cleared", 32'(timeout), 32'd0);
    check("to_clear_no_valid", 32'(period_valid), 32'd0);
    repeat (4) step(1'b0);
    step(1'b1); step(1'b0); step(1'b0);
    check("after_to_valid", 32'(period_valid), 32'd1);
    check("after_to_period", 32'(period), 32'd7);
    $display("timeout sequence: period=%0d timeout=%0d", period, timeout);

    // Asynchronous reset mid-measurement (cnt = 9).
    do_reset();
    step(1'b1); step(1'b0); step(1'b0);
    repeat (9) step(1'b0);
    check("pre_reset_toggle", 32'(toggle), 32'd1);
    #2;
    do_reset();
    obs_valids = 0;
    step(1'b1);
    repeat (4) step(1'b0);
    check("post_reset_no_valid", 32'(obs_valids), 32'd0);
    check("post_reset_edge_count", 32'(edge_count), 32'd1);
    $display("async reset sequence: edge_count=%0d toggle=%0d", edge_count, toggle);

    // pulse_in held high through reset yields one rise after release.
    pulse_in = 1'b1;
    do_reset();
    repeat (4) step(1'b1);
    check("held_high_edge_count", 32'(edge_count), 32'd1);
    repeat (3) step(1'b0);
    $display("held-high reset sequence: edge_count=%0d", edge_count);

    // Random run lengths, long enough to exercise timeouts.
    do_reset();
    lvl = 1'b0;
    for (int n = 0; n < 120; n++) begin
      run_len = $urandom_range(1, 25);
      repeat (run_len) step(lvl);
      lvl = ~lvl;
    end
    $display("random phase: edge_count=%0d period=%0d timeout=%0d", edge_count, period, timeout);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Receive-side companion to the team's periodic tick generators. It takes a pulse train from another clock region or an external pin and synchronizes it. It detects rising edges and measures the interval between consecutive edges in `clock` cycles. It reports each interval with a one-cycle valid strobe, flags missing pulses with a timeout, and drives a toggle output that can feed an LED directly.

## Interface
Parameters:
- `WIDTH`, 26: width of the interval counter and of `period`.
- `TIMEOUT`, 50_000_000: number of cycles without a rising edge that declares loss of signal. Legal range is 2 to 2^WIDTH−1.

Ports:
- `clock`, in, 1: single clock. All logic is clocked on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `pulse_in`, in, 1: asynchronous pulse train input.
- `period`, out, WIDTH: last measured interval between rising edges, in cycles.
- `period_valid`, out, 1: one-cycle strobe, high when `period` has just been updated.
- `timeout`, out, 1: level output. High while no rising edge has arrived for `TIMEOUT` cycles.
- `toggle`, out, 1: inverts on every accepted rising edge.
- `edge_count`, out, 8: count of accepted rising edges. Wraps from 255 to 0.

## Operation
- Synchronizer: `pulse_in` passes through flops s1 and s2, with s3 as the history flop. rise = s2 & ~s3. All three flops reset to 0.
  - A `pulse_in` held high through reset therefore produces one rise after reset is released.
- Interval counter `cnt` is WIDTH bits wide.
- FSM states are IDLE, MEASURE and LOST.
- IDLE (the reset state):
  - `cnt` is held at 0.
  - On rise: go to MEASURE, set `cnt` to 0, flip `toggle`, increment `edge_count`.
  - No `period_valid` is produced, because there is no earlier edge to measure from.
- MEASURE:
  - When rise is not asserted, `cnt` increments by 1 each cycle.
  - On rise: set `period` to `cnt`+1, pulse `period_valid`, set `cnt` to 0, flip `toggle`, increment `edge_count`.
  - Edges exactly N cycles apart therefore report `period` = N.
  - When `cnt` = `TIMEOUT`−1 and rise is not asserted: go to LOST, set `timeout` to 1, set `cnt` to 0.
  - If rise and `cnt` = `TIMEOUT`−1 occur in the same cycle, rise wins: `period` = `TIMEOUT`, `period_valid` pulses, and there is no timeout.
- LOST:
  - `timeout` is held at 1 and `cnt` is held at 0.
  - `period` keeps its last value.
  - On rise: go to MEASURE, clear `timeout`, flip `toggle`, increment `edge_count`. No `period_valid` is produced; the edge restarts measurement just as in IDLE.
- Arithmetic: `cnt`+1 is computed at WIDTH bits. Overflow is impossible because `cnt` < `TIMEOUT` ≤ 2^WIDTH−1.
- Reset asserted at any time, including mid-measurement:
  - All state is discarded immediately and the FSM returns to IDLE.
  - The first rise after reset is treated as a first edge.

## Timing
- Reset values: `period` = 0, `period_valid` = 0, `timeout` = 0, `toggle` = 0, `edge_count` = 0. FSM is in IDLE. s1, s2, s3 and `cnt` are 0.
- Outputs are registered and change only on a `clock` rising edge, or immediately on assertion of `reset`.
- Latency: `pulse_in` first sampled high at edge E0 → s1 high after E0 → s2 high after E1 → rise during E1–E2 → outputs updated at E2.
- `period_valid` is high for exactly one cycle per measured interval. It is never high on two consecutive cycles, because consecutive rises need at least 2 cycles.
- A high phase of any length produces a single rise. The minimum detectable pulse is one full cycle high followed by one full cycle low, as seen by s2.
- `timeout` rises exactly `TIMEOUT` cycles after the register update caused by the last rise. It falls at the update caused by the next rise.

## Test plan
All scenarios use `WIDTH` = 26 and `TIMEOUT` = 20.
1. Release reset, then drive 1-cycle pulses every 11 cycles for 5 pulses → first pulse: no valid, `toggle` = 1, `edge_count` = 1. Then 4 `period_valid` strobes with `period` = 11. Finally `toggle` = 1, `edge_count` = 5.
2. Hold `pulse_in` high for 6 cycles, then drop it → exactly one rise: `edge_count` increments by 1 and `toggle` flips once. A second identical pulse 15 cycles after the first rising edge gives `period` = 15.
3. One pulse, then silence → `timeout` = 1 exactly 20 cycles after the rise update. The next pulse clears `timeout` with no valid. A pulse 7 cycles after that gives `period` = 7.
4. Pulses exactly 20 cycles apart → `period` = 20 with `period_valid` high, and `timeout` stays 0. Pulses 21 cycles apart → `timeout` asserts, and no valid is produced for the late pulse.
5. Assert `reset` asynchronously mid-measurement (`cnt` = 9, `toggle` = 1) → all outputs read 0 before the next `clock` edge. The next pulse after release produces no valid.
6. Drive 257 pulses 4 cycles apart → `edge_count` wraps 255 → 0 → 1. Every `period` = 4. `toggle` ends at 1.
